// File: rtl/gpo_pad_seq_pkg.sv
// gpo_pad_seq_pkg: shared types and constants for the pad reconfiguration sequencer
package gpo_pad_seq_pkg;
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [2:0] {ST_RUN, ST_BREAK, ST_APPLY, ST_BIAS_WAIT, ST_SETTLE} state_t;
    typedef enum logic [1:0] {MODE_PP = 2'b00, MODE_ODL = 2'b01, MODE_ODH = 2'b10, MODE_DIS = 2'b11} mode_t;
    typedef enum logic [1:0] {DS_OFF = 2'b00, DS_LO = 2'b01, DS_MID = 2'b10, DS_HI = 2'b11} ds_t;
endpackage

// File: rtl/gpo_pad_seq_if.sv
// gpo_pad_seq_if: configuration request and pad control bundle
interface gpo_pad_seq_if;
    logic       cfg_valid_i, cfg_ready_o, cfg_sr_i;
    logic [1:0] cfg_ds_i, cfg_mode_i;
    logic       data_i, oe_i, vbias_ok_i, fault_clr_i;
    logic       pad_do_o, pad_oe_o, pad_odp_o, pad_odn_o, pad_sr_o, pad_co_o;
    logic [1:0] pad_ds_o;
    logic       busy_o, fault_o;
    modport master (
        output cfg_valid_i, cfg_ds_i, cfg_sr_i, cfg_mode_i, data_i, oe_i, vbias_ok_i, fault_clr_i,
        input  cfg_ready_o, pad_do_o, pad_oe_o, pad_odp_o, pad_odn_o, pad_sr_o, pad_co_o, pad_ds_o,
               busy_o, fault_o
    );
    modport slave (
        input  cfg_valid_i, cfg_ds_i, cfg_sr_i, cfg_mode_i, data_i, oe_i, vbias_ok_i, fault_clr_i,
        output cfg_ready_o, pad_do_o, pad_oe_o, pad_odp_o, pad_odn_o, pad_sr_o, pad_co_o, pad_ds_o,
               busy_o, fault_o
    );
endinterface

// File: rtl/gpo_sync2.sv
// gpo_sync2: two-flop synchronizer for an asynchronous level, cleared by reset
module gpo_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/gpo_pad_seq.sv
// gpo_pad_seq: sequences pad reconfiguration through break, apply, bias wait and settle,
// keeping the pad tristated whenever the sequence is not in RUN.
module gpo_pad_seq
    import gpo_pad_seq_pkg::*;
#(
    parameter int BREAK_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int VBIAS_TMO  = 1024
) (
    input logic clk,
    input logic rst,
    gpo_pad_seq_if.slave bus
);
    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    logic       vb_s, bias_lost, ready, accept, ds_kill, fault_set, pad_oe;
    logic [1:0] pend_ds, ds;
    logic       pend_sr, sr, oe_q, do_q, odp, odn, fault;
    mode_t      pend_mode, mode;

    gpo_sync2 u_sync (.clk(clk), .rst(rst), .d(bus.vbias_ok_i), .q(vb_s));

    assign bias_lost = state == ST_RUN && ds != DS_OFF && !vb_s;
    assign ready     = state == ST_RUN && !bias_lost;
    assign accept    = bus.cfg_valid_i && ready;
    assign fault_set = bias_lost || ds_kill;

    always_comb begin
        state_n = state;
        ds_kill = 1'b0;
        case (state)
            ST_RUN:       state_n = bias_lost ? ST_BIAS_WAIT : accept ? ST_BREAK : ST_RUN;
            ST_BREAK:     state_n = cnt <= cnt_t'(1) ? ST_APPLY : ST_BREAK;
            ST_APPLY:     state_n = pend_ds != DS_OFF ? ST_BIAS_WAIT : ST_SETTLE;
            ST_BIAS_WAIT: begin
                ds_kill = !vb_s && cnt <= cnt_t'(1);
                state_n = (vb_s || ds_kill) ? ST_SETTLE : ST_BIAS_WAIT;
            end
            ST_SETTLE:    state_n = cnt <= cnt_t'(1) ? ST_RUN : ST_SETTLE;
            default:      state_n = ST_SETTLE;
        endcase
        // one shared counter: reload on every state change, otherwise count down and stop at zero
        cnt_n = state_n == state ? (cnt != '0 ? cnt - cnt_t'(1) : '0)
              : state_n == ST_BREAK     ? cnt_t'(BREAK_CYC)
              : state_n == ST_BIAS_WAIT ? cnt_t'(VBIAS_TMO)
              : state_n == ST_SETTLE    ? cnt_t'(SETTLE_CYC) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SETTLE;
            cnt       <= cnt_t'(SETTLE_CYC);
            pend_ds   <= DS_OFF;
            pend_sr   <= 1'b0;
            pend_mode <= MODE_DIS;
            ds        <= DS_OFF;
            sr        <= 1'b0;
            mode      <= MODE_DIS;
            odp       <= 1'b0;
            odn       <= 1'b0;
            oe_q      <= 1'b0;
            do_q      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                pend_ds   <= bus.cfg_ds_i;
                pend_sr   <= bus.cfg_sr_i;
                pend_mode <= mode_t'(bus.cfg_mode_i);
            end
            if (state == ST_APPLY) begin
                ds   <= pend_ds;
                sr   <= pend_sr;
                mode <= pend_mode;
                odp  <= pend_mode == MODE_ODL;
                odn  <= pend_mode == MODE_ODH;
            end
            if (ds_kill) ds <= DS_OFF;
            oe_q  <= bus.oe_i;
            do_q  <= bus.data_i;
            fault <= fault_set || (fault && !bus.fault_clr_i);
        end
    end

    assign pad_oe          = state == ST_RUN && oe_q && mode != MODE_DIS;
    assign bus.cfg_ready_o = ready;
    assign bus.pad_oe_o    = pad_oe;
    assign bus.pad_co_o    = pad_oe;
    assign bus.pad_do_o    = do_q;
    assign bus.pad_ds_o    = ds;
    assign bus.pad_sr_o    = sr;
    assign bus.pad_odp_o   = odp;
    assign bus.pad_odn_o   = odn;
    assign bus.busy_o      = state != ST_RUN;
    assign bus.fault_o     = fault;
endmodule

// File: tb/tb_gpo_pad_seq.sv
// tb_gpo_pad_seq: two sequencers (short and long bias timeout) driven in lockstep,
// each compared every cycle against a deadline-based reference model plus directed checks.
module tb_gpo_pad_seq;
    localparam int BRK = 4, STL = 8;
    localparam int P_RUN = 0, P_BRK = 1, P_APP = 2, P_BIAS = 3, P_STL = 4;
    localparam logic [10:0] RST_V = 11'b000_0000_0010;

    logic       clk = 0, rst = 1, cfg_valid = 0, sr = 0, data = 0, oe = 0, vbias = 0, fclr = 0;
    logic [1:0] ds = 0, mode = 0;
    int         tmo[2] = '{16, 1024};
    int         edge_n = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    gpo_pad_seq_if if_a ();
    gpo_pad_seq_if if_b ();
    assign if_a.cfg_valid_i = cfg_valid;
    assign if_a.cfg_ds_i    = ds;
    assign if_a.cfg_sr_i    = sr;
    assign if_a.cfg_mode_i  = mode;
    assign if_a.data_i      = data;
    assign if_a.oe_i        = oe;
    assign if_a.vbias_ok_i  = vbias;
    assign if_a.fault_clr_i = fclr;
    assign if_b.cfg_valid_i = cfg_valid;
    assign if_b.cfg_ds_i    = ds;
    assign if_b.cfg_sr_i    = sr;
    assign if_b.cfg_mode_i  = mode;
    assign if_b.data_i      = data;
    assign if_b.oe_i        = oe;
    assign if_b.vbias_ok_i  = vbias;
    assign if_b.fault_clr_i = fclr;

    gpo_pad_seq #(.BREAK_CYC(BRK), .SETTLE_CYC(STL), .VBIAS_TMO(16))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    gpo_pad_seq #(.BREAK_CYC(BRK), .SETTLE_CYC(STL), .VBIAS_TMO(1024))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    // {ready, do, oe, odp, odn, sr, co, ds[1:0], busy, fault}
    logic [10:0] got[2];
    assign got[0] = {if_a.cfg_ready_o, if_a.pad_do_o, if_a.pad_oe_o, if_a.pad_odp_o, if_a.pad_odn_o,
                     if_a.pad_sr_o, if_a.pad_co_o, if_a.pad_ds_o, if_a.busy_o, if_a.fault_o};
    assign got[1] = {if_b.cfg_ready_o, if_b.pad_do_o, if_b.pad_oe_o, if_b.pad_odp_o, if_b.pad_odn_o,
                     if_b.pad_sr_o, if_b.pad_co_o, if_b.pad_ds_o, if_b.busy_o, if_b.fault_o};

    // model: current phase plus the edge number at which it ends
    typedef struct {
        int ph; int done_at;
        logic [1:0] pds; logic psr; logic [1:0] pmode;
        logic [1:0] ds; logic sr; logic [1:0] mode;
        logic fault, do_r, oe_r;
        logic [1:0] vh;
    } mdl_t;
    mdl_t m[2];

    typedef struct packed {
        logic [1:0] ds; logic sr; logic [1:0] mode; logic odp, odn, oe;
    } vec_t;
    vec_t tbl[5];

    task automatic enter(input int k, input int p, input int d);
        m[k].ph = p;
        m[k].done_at = edge_n + d;
    endtask

    task automatic model_edge(input int k);
        logic vbs, lost, fs;
        vbs  = m[k].vh[1];
        lost = m[k].ph == P_RUN && m[k].ds != 2'b00 && !vbs;
        fs   = 1'b0;
        if (rst) begin
            enter(k, P_STL, STL);
            m[k].pds = 0; m[k].psr = 0; m[k].pmode = 3;
            m[k].ds = 0; m[k].sr = 0; m[k].mode = 3;
            m[k].fault = 0; m[k].do_r = 0; m[k].oe_r = 0; m[k].vh = 0;
        end else begin
            case (m[k].ph)
                P_RUN: if (lost) begin fs = 1; enter(k, P_BIAS, tmo[k]); end
                       else if (cfg_valid) begin
                           m[k].pds = ds; m[k].psr = sr; m[k].pmode = mode;
                           enter(k, P_BRK, BRK);
                       end
                P_BRK: if (edge_n == m[k].done_at) enter(k, P_APP, 1);
                P_APP: begin
                    m[k].ds = m[k].pds; m[k].sr = m[k].psr; m[k].mode = m[k].pmode;
                    if (m[k].pds != 0) enter(k, P_BIAS, tmo[k]);
                    else enter(k, P_STL, STL);
                end
                P_BIAS: if (vbs) enter(k, P_STL, STL);
                        else if (edge_n == m[k].done_at) begin fs = 1; m[k].ds = 0; enter(k, P_STL, STL); end
                default: if (edge_n == m[k].done_at) enter(k, P_RUN, 0);
            endcase
            m[k].fault = fs | (m[k].fault & ~fclr);
            m[k].do_r  = data;
            m[k].oe_r  = oe;
            m[k].vh    = {m[k].vh[0], vbias};
        end
    endtask

    function automatic logic [10:0] exp_v(input int k);
        logic run, rdy, poe;
        run = m[k].ph == P_RUN;
        rdy = run && !(m[k].ds != 0 && !m[k].vh[1]);
        poe = run && m[k].oe_r && m[k].mode != 2'b11;
        return {rdy, m[k].do_r, poe, m[k].mode == 2'b01, m[k].mode == 2'b10, m[k].sr, poe,
                m[k].ds, !run, m[k].fault};
    endfunction

    task automatic chk(input string name, input logic [10:0] g, input logic [10:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s edge %0d got %b expected %b", name, edge_n, g, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k == 0 ? "trace_a" : "trace_b", got[k], exp_v(k));
    endtask

    task automatic wait_run(input int lim);
        int n = 0;
        while ((m[0].ph != P_RUN || m[1].ph != P_RUN) && n < lim) begin step(); n++; end
        if (m[0].ph != P_RUN || m[1].ph != P_RUN) begin
            checks++; errors++;
            $display("FAIL wait_run no RUN after %0d cycles", lim);
        end
    endtask

    task automatic send(input logic [1:0] d, input logic s, input logic [1:0] md);
        ds = d; sr = s; mode = md; cfg_valid = 1;
        step();
        cfg_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, then the settle gap after release
        data = 1; oe = 1; vbias = 0;
        rst = 1; step(); step(); rst = 0;
        chk("rst_state_a", got[0], RST_V);
        chk("rst_state_b", got[1], RST_V);
        for (int i = 1; i <= 8; i++) begin
            chk("settle_ready_lo", if_a.cfg_ready_o, 0);
            chk("settle_oe_lo", if_a.pad_oe_o, 0);
            if (i < 8) step();
        end
        step();
        chk("run_ready_hi", if_a.cfg_ready_o, 1);
        chk("run_oe_dis_mode", if_a.pad_oe_o, 0);

        // DS=00 push-pull: 4 break + 1 apply + 8 settle with pad tristated
        send(2'd0, 1'b1, 2'd0);
        for (int i = 1; i <= 13; i++) begin
            chk("pp_oe_off", if_a.pad_oe_o, 0);
            data = 1'($urandom_range(1));
            step();
            chk("pp_do_track", if_a.pad_do_o, data);
        end
        chk("pp_oe_on", if_a.pad_oe_o, 1);
        chk("pp_busy_lo", if_b.busy_o, 0);

        // DS=11, bias arrives late: long timeout waits, short timeout faults
        vbias = 0; step(); step(); step();
        send(2'd3, 1'b0, 2'd0);
        repeat (22) step();
        vbias = 1; step(); step();
        chk("short_tmo_fault", if_a.fault_o, 1);
        chk("short_tmo_ds_off", if_a.pad_ds_o, 0);
        step();
        chk("late_bias_ds", if_b.pad_ds_o, 3);
        chk("late_bias_no_fault", if_b.fault_o, 0);
        repeat (7) step();
        chk("late_bias_busy", if_b.busy_o, 1);
        step();
        chk("late_bias_run", if_b.busy_o, 0);
        chk("late_bias_ready", if_b.cfg_ready_o, 1);

        // DS=10 with bias never arriving, 16-cycle timeout
        do_reset(); vbias = 0; wait_run(20);
        send(2'd2, 1'b0, 2'd0);
        repeat (20) step();
        chk("tmo_pre_fault", if_a.fault_o, 0);
        step();
        chk("tmo_fault", if_a.fault_o, 1);
        chk("tmo_ds_off", if_a.pad_ds_o, 0);
        repeat (8) step();
        chk("tmo_run", if_a.busy_o, 0);
        chk("tmo_oe_on", if_a.pad_oe_o, 1);

        // bias loss in RUN, fault set beats simultaneous clear, then sticky until cleared
        do_reset(); vbias = 1; wait_run(20);
        send(2'd1, 1'b0, 2'd0);
        wait_run(40);
        step();
        chk("loss_pre_oe", if_a.pad_oe_o, 1);
        vbias = 0; fclr = 1;
        step(); step(); step();
        chk("loss_oe_off", if_a.pad_oe_o, 0);
        chk("loss_fault_a", if_a.fault_o, 1);
        chk("loss_fault_b", if_b.fault_o, 1);
        fclr = 0; vbias = 1;
        wait_run(30);
        chk("fault_sticky", if_a.fault_o, 1);
        fclr = 1; step(); fclr = 0;
        chk("fault_clr_a", if_a.fault_o, 0);
        chk("fault_clr_b", if_b.fault_o, 0);

        // table of configurations applied with bias present
        tbl = '{'{2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1},
                '{2'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1},
                '{2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0},
                '{2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1},
                '{2'd0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            wait_run(40);
            send(tbl[i].ds, tbl[i].sr, tbl[i].mode);
            wait_run(40);
            step();
            chk("tbl_ds", if_a.pad_ds_o, tbl[i].ds);
            chk("tbl_sr", if_a.pad_sr_o, tbl[i].sr);
            chk("tbl_odp", if_a.pad_odp_o, tbl[i].odp);
            chk("tbl_odn", if_a.pad_odn_o, tbl[i].odn);
            chk("tbl_od_excl", if_a.pad_odp_o & if_a.pad_odn_o, 0);
            chk("tbl_oe", if_a.pad_oe_o, tbl[i].oe);
        end

        // reset during BREAK drops the pending configuration
        send(2'd2, 1'b1, 2'd1);
        step(); step();
        do_reset();
        chk("brk_rst_a", got[0], RST_V);
        wait_run(20);
        step();
        chk("brk_rst_ds", if_a.pad_ds_o, 0);
        chk("brk_rst_sr", if_a.pad_sr_o, 0);
        chk("brk_rst_odp", if_a.pad_odp_o, 0);
        chk("brk_rst_oe", if_a.pad_oe_o, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = $urandom_range(9) == 0;
            ds   = 2'($urandom_range(3));
            sr   = 1'($urandom_range(1));
            mode = 2'($urandom_range(3));
            data = 1'($urandom_range(1));
            oe   = $urandom_range(7) != 0;
            if ($urandom_range(63) == 0) vbias = ~vbias;
            fclr = $urandom_range(15) == 0;
            rst  = $urandom_range(499) == 0;
            step();
        end
        rst = 0; cfg_valid = 0; fclr = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
